romload_seq: RTL and testbench

ROMLOAD_SEQ -- requirements
Module: romload_seq

---
 rtl/romload_seq.sv | 175 +++++++++++++++++
 tb/tb_romload_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/romload_seq.sv
// romload_seq: streams HPS ROM download bytes into a shared ROM write port
// and sequences the game-core reset around the load.
//
// Ports
//   MCLK       in   1   clock, rising edge
//   RESET_N    in   1   asynchronous active-low reset
//   DL_ACTIVE  in   1   download in progress
//   DL_WR      in   1   one-cycle byte strobe
//   DL_AD      in  25   download byte address
//   DL_DT      in   8   download byte
//   WR_REQ     out  1   write request (FIFO non-empty)
//   WR_ACK     in   1   write accepted this cycle
//   WR_SEL     out  4   one-hot region select of head entry
//   WR_AD      out 16   offset within region of head entry
//   WR_DT      out  8   data of head entry
//   CORE_RST   out  1   core reset hold, low only once loaded
//   LOAD_DONE  out  1   image loaded, core running
//   ERR_OVF    out  1   sticky, byte dropped on full FIFO
//   BYTE_CNT   out 25   bytes accepted in current load
//
// state | meaning
// IDLE  | after reset, waiting for a download
// LOAD  | download active, bytes queued into the FIFO
// DRAIN | download finished, FIFO still emptying
// HOLD  | FIFO empty, core held in reset for POST_HOLD cycles
// DONE  | core released
module romload_seq #(
    parameter logic [24:0] BASE1     = 25'h08000,
    parameter logic [24:0] BASE2     = 25'h10000,
    parameter logic [24:0] BASE3     = 25'h18000,
    parameter logic [24:0] TOP       = 25'h20000,
    parameter int unsigned POST_HOLD = 16
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        DL_ACTIVE,
    input  logic        DL_WR,
    input  logic [24:0] DL_AD,
    input  logic [7:0]  DL_DT,
    output logic        WR_REQ,
    input  logic        WR_ACK,
    output logic [3:0]  WR_SEL,
    output logic [15:0] WR_AD,
    output logic [7:0]  WR_DT,
    output logic        CORE_RST,
    output logic        LOAD_DONE,
    output logic        ERR_OVF,
    output logic [24:0] BYTE_CNT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] HOLD_INIT = 16'(POST_HOLD);

    state_t      state, state_nx;
    logic [15:0] hold_cnt;

    logic [27:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;

    logic [3:0]  dec_sel;
    logic [15:0] dec_base;
    logic [15:0] dec_off;
    logic        accept, full, push, pop, drop, load_entry;
    logic [27:0] head;

    // Region decode; offset only needs the low 16 bits, so subtract there.
    always_comb begin
        dec_sel  = 4'b0001;
        dec_base = 16'd0;
        if (DL_AD >= BASE3) begin
            dec_sel  = 4'b1000;
            dec_base = BASE3[15:0];
        end else if (DL_AD >= BASE2) begin
            dec_sel  = 4'b0100;
            dec_base = BASE2[15:0];
        end else if (DL_AD >= BASE1) begin
            dec_sel  = 4'b0010;
            dec_base = BASE1[15:0];
        end
        dec_off = DL_AD[15:0] - dec_base;
    end

    assign accept = (state == LOAD) && DL_WR && (DL_AD < TOP);
    assign full   = (count == 3'd4);
    assign pop    = WR_REQ && WR_ACK;
    // A full FIFO still takes the byte when the head leaves on the same edge.
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;
    assign head   = mem[rd_ptr];

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {dec_sel, dec_off, DL_DT};
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        WR_REQ    = (count != 3'd0);
        WR_SEL    = 4'd0;
        WR_AD     = 16'd0;
        WR_DT     = 8'd0;
        CORE_RST  = 1'b1;
        LOAD_DONE = 1'b0;
        if (WR_REQ) begin
            WR_SEL = head[27:24];
            WR_AD  = head[23:8];
            WR_DT  = head[7:0];
        end
        case (state)
            IDLE:    if (DL_ACTIVE) state_nx = LOAD;
            LOAD:    if (!DL_ACTIVE) state_nx = DRAIN;
            DRAIN:   if (count == 3'd0) state_nx = HOLD;
            HOLD: begin
                if (DL_ACTIVE)              state_nx = LOAD;
                else if (hold_cnt <= 16'd1) state_nx = DONE;
            end
            DONE: begin
                CORE_RST  = 1'b0;
                LOAD_DONE = 1'b1;
                if (DL_ACTIVE) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign load_entry = (state_nx == LOAD) && (state != LOAD);

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_cnt <= '0;
        end else if (state == DRAIN && state_nx == HOLD) begin
            hold_cnt <= HOLD_INIT;
        end else if (state == HOLD && hold_cnt != 16'd0) begin
            hold_cnt <= hold_cnt - 16'd1;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BYTE_CNT <= '0;
            ERR_OVF  <= 1'b0;
        end else if (load_entry) begin
            BYTE_CNT <= '0;
            ERR_OVF  <= 1'b0;
        end else begin
            if (push) BYTE_CNT <= BYTE_CNT + 25'd1;
            if (drop) ERR_OVF  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_romload_seq.sv
module tb_romload_seq;

    localparam int POST_HOLD = 16;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic        DL_ACTIVE;
    logic        DL_WR;
    logic [24:0] DL_AD;
    logic [7:0]  DL_DT;
    logic        WR_REQ;
    logic        WR_ACK;
    logic [3:0]  WR_SEL;
    logic [15:0] WR_AD;
    logic [7:0]  WR_DT;
    logic        CORE_RST;
    logic        LOAD_DONE;
    logic        ERR_OVF;
    logic [24:0] BYTE_CNT;

    int errors = 0;
    int checks = 0;
    logic [27:0] sb [$];

    romload_seq #(.POST_HOLD(POST_HOLD)) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .DL_ACTIVE(DL_ACTIVE), .DL_WR(DL_WR),
        .DL_AD(DL_AD), .DL_DT(DL_DT), .WR_REQ(WR_REQ), .WR_ACK(WR_ACK),
        .WR_SEL(WR_SEL), .WR_AD(WR_AD), .WR_DT(WR_DT), .CORE_RST(CORE_RST),
        .LOAD_DONE(LOAD_DONE), .ERR_OVF(ERR_OVF), .BYTE_CNT(BYTE_CNT)
    );

    always #5 MCLK = ~MCLK;

    // Reference decode of the default memory map.
    function automatic logic [27:0] exp_of(input logic [24:0] a, input logic [7:0] d);
        logic [24:0] off;
        if (a >= 25'h18000)      begin off = a - 25'h18000; return {4'b1000, off[15:0], d}; end
        else if (a >= 25'h10000) begin off = a - 25'h10000; return {4'b0100, off[15:0], d}; end
        else if (a >= 25'h08000) begin off = a - 25'h08000; return {4'b0010, off[15:0], d}; end
        else                     return {4'b0001, a[15:0], d};
    endfunction

    // Every write taken by the port must match the oldest expected entry.
    always @(negedge MCLK) begin
        if (RESET_N === 1'b1 && WR_REQ === 1'b1 && WR_ACK === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h, none expected", {WR_SEL, WR_AD, WR_DT});
            end else begin
                logic [27:0] e;
                e = sb.pop_front();
                if ({WR_SEL, WR_AD, WR_DT} !== e) begin
                    errors++;
                    $display("FAIL write_order: got %h, expected %h", {WR_SEL, WR_AD, WR_DT}, e);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge MCLK);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        DL_AD = a;
        DL_DT = d;
        DL_WR = 1'b1;
        tick();
        DL_WR = 1'b0;
    endtask

    task automatic start_load;
        DL_ACTIVE = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; DL_ACTIVE = 0; DL_WR = 0; DL_AD = 0; DL_DT = 0; WR_ACK = 0;
        #12;
        checks++;
        if ({WR_REQ, WR_SEL, WR_AD, WR_DT} !== 29'd0) begin
            errors++; $display("FAIL reset_wr: got %h, expected 0", {WR_REQ, WR_SEL, WR_AD, WR_DT});
        end
        checks++;
        if ({CORE_RST, LOAD_DONE, ERR_OVF} !== 3'b100) begin
            errors++; $display("FAIL reset_ctl: got %b, expected 100", {CORE_RST, LOAD_DONE, ERR_OVF});
        end
        checks++;
        if (BYTE_CNT !== 25'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d, expected 0", BYTE_CNT);
        end
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int n;
        WR_ACK = 1'b1;
        start_load();
        sb.push_back({4'b0001, 16'h0000, 8'hA1}); strobe(25'h00000, 8'hA1);
        sb.push_back({4'b0010, 16'h0001, 8'hA2}); strobe(25'h08001, 8'hA2);
        sb.push_back({4'b1000, 16'h7FFF, 8'hA3}); strobe(25'h1FFFF, 8'hA3);
        for (n = 0; n < 20 && sb.size() != 0; n++) tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL basic_drain: got %0d pending, expected 0", sb.size());
        end
        checks++;
        if (BYTE_CNT !== 25'd3) begin
            errors++; $display("FAIL basic_cnt: got %0d, expected 3", BYTE_CNT);
        end
        checks++;
        if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0) begin
            errors++; $display("FAIL basic_loading: got rst=%b done=%b, expected 1 0", CORE_RST, LOAD_DONE);
        end
        DL_ACTIVE = 1'b0;
        for (n = 0; n < 100 && LOAD_DONE !== 1'b1; n++) tick();
        checks++;
        if (LOAD_DONE !== 1'b1 || CORE_RST !== 1'b0) begin
            errors++; $display("FAIL basic_done: got done=%b rst=%b, expected 1 0", LOAD_DONE, CORE_RST);
        end
    endtask

    task automatic test_overflow;
        logic [24:0] addrs [5];
        logic [27:0] first;
        int n;
        addrs = '{25'h08000, 25'h10005, 25'h00007, 25'h1800A, 25'h0FFFF};
        first = exp_of(addrs[0], 8'h11);
        WR_ACK = 1'b0;
        start_load();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(exp_of(addrs[i], 8'(8'h11 + i)));
            strobe(addrs[i], 8'(8'h11 + i));
            checks++;
            if (WR_REQ !== 1'b1 || {WR_SEL, WR_AD, WR_DT} !== first) begin
                errors++;
                $display("FAIL ovf_head_stable: got req=%b %h, expected 1 %h", WR_REQ, {WR_SEL, WR_AD, WR_DT}, first);
            end
        end
        checks++;
        if (ERR_OVF !== 1'b1) begin
            errors++; $display("FAIL ovf_flag: got %b, expected 1", ERR_OVF);
        end
        checks++;
        if (BYTE_CNT !== 25'd4) begin
            errors++; $display("FAIL ovf_cnt: got %0d, expected 4", BYTE_CNT);
        end
        WR_ACK = 1'b1;
        for (n = 0; n < 20 && sb.size() != 0; n++) tick();
        tick();
        checks++;
        if (sb.size() != 0 || WR_REQ !== 1'b0) begin
            errors++; $display("FAIL ovf_drain: got %0d pending req=%b, expected 0 0", sb.size(), WR_REQ);
        end
        DL_ACTIVE = 1'b0;
        for (n = 0; n < 100 && LOAD_DONE !== 1'b1; n++) tick();
    endtask

    task automatic test_hold;
        int n;
        WR_ACK = 1'b0;
        start_load();
        checks++;
        if (ERR_OVF !== 1'b0 || BYTE_CNT !== 25'd0) begin
            errors++; $display("FAIL hold_entry_clear: got ovf=%b cnt=%0d, expected 0 0", ERR_OVF, BYTE_CNT);
        end
        sb.push_back(exp_of(25'h00042, 8'h5A)); strobe(25'h00042, 8'h5A);
        sb.push_back(exp_of(25'h10100, 8'hA5)); strobe(25'h10100, 8'hA5);
        DL_ACTIVE = 1'b0;
        for (int k = 0; k < 2; k++) begin
            repeat (3) begin
                tick();
                checks++;
                if (WR_REQ !== 1'b1 || {WR_SEL, WR_AD, WR_DT} !== sb[0] || CORE_RST !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_wait_stable: got req=%b %h rst=%b, expected 1 %h 1", WR_REQ, {WR_SEL, WR_AD, WR_DT}, sb[0], CORE_RST);
                end
            end
            WR_ACK = 1'b1;
            tick();
            WR_ACK = 1'b0;
        end
        // One empty-FIFO DRAIN cycle, then POST_HOLD cycles of HOLD.
        n = 0;
        @(negedge MCLK);
        while (CORE_RST === 1'b1 && n < 100) begin
            n++;
            @(negedge MCLK);
        end
        checks++;
        if (n != 1 + POST_HOLD) begin
            errors++; $display("FAIL hold_length: got %0d cycles, expected %0d", n, 1 + POST_HOLD);
        end
        checks++;
        if (LOAD_DONE !== 1'b1 || sb.size() != 0) begin
            errors++; $display("FAIL hold_done: got done=%b pending=%0d, expected 1 0", LOAD_DONE, sb.size());
        end
        tick();
    endtask

    task automatic test_top;
        int n;
        WR_ACK = 1'b1;
        start_load();
        sb.push_back(exp_of(25'h1FFFF, 8'h77)); strobe(25'h1FFFF, 8'h77);
        strobe(25'h20000, 8'h88);
        strobe(25'h1FFFFFF, 8'h99);
        repeat (3) tick();
        checks++;
        if (BYTE_CNT !== 25'd1 || ERR_OVF !== 1'b0) begin
            errors++; $display("FAIL top_discard: got cnt=%0d ovf=%b, expected 1 0", BYTE_CNT, ERR_OVF);
        end
        checks++;
        if (sb.size() != 0 || WR_REQ !== 1'b0) begin
            errors++; $display("FAIL top_nowrite: got pending=%0d req=%b, expected 0 0", sb.size(), WR_REQ);
        end
        DL_ACTIVE = 1'b0;
        for (n = 0; n < 100 && LOAD_DONE !== 1'b1; n++) tick();
        strobe(25'h00010, 8'h42);
        repeat (3) tick();
        checks++;
        if (BYTE_CNT !== 25'd1 || WR_REQ !== 1'b0 || LOAD_DONE !== 1'b1) begin
            errors++; $display("FAIL ignore_outside_load: got cnt=%0d req=%b done=%b, expected 1 0 1", BYTE_CNT, WR_REQ, LOAD_DONE);
        end
    endtask

    task automatic test_restart;
        int n;
        WR_ACK = 1'b1;
        start_load();
        sb.push_back(exp_of(25'h08100, 8'h3C)); strobe(25'h08100, 8'h3C);
        DL_ACTIVE = 1'b0;
        repeat (6) tick();
        checks++;
        if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0 || BYTE_CNT !== 25'd1) begin
            errors++; $display("FAIL restart_in_hold: got rst=%b done=%b cnt=%0d, expected 1 0 1", CORE_RST, LOAD_DONE, BYTE_CNT);
        end
        DL_ACTIVE = 1'b1;
        tick();
        checks++;
        if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0 || BYTE_CNT !== 25'd0) begin
            errors++; $display("FAIL restart_from_hold: got rst=%b done=%b cnt=%0d, expected 1 0 0", CORE_RST, LOAD_DONE, BYTE_CNT);
        end
        sb.push_back(exp_of(25'h18001, 8'hC3)); strobe(25'h18001, 8'hC3);
        DL_ACTIVE = 1'b0;
        for (n = 0; n < 100 && LOAD_DONE !== 1'b1; n++) tick();
        checks++;
        if (LOAD_DONE !== 1'b1 || BYTE_CNT !== 25'd1) begin
            errors++; $display("FAIL restart_reach_done: got done=%b cnt=%0d, expected 1 1", LOAD_DONE, BYTE_CNT);
        end
        DL_ACTIVE = 1'b1;
        tick();
        checks++;
        if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0 || BYTE_CNT !== 25'd0) begin
            errors++; $display("FAIL restart_from_done: got rst=%b done=%b cnt=%0d, expected 1 0 0", CORE_RST, LOAD_DONE, BYTE_CNT);
        end
        DL_ACTIVE = 1'b0;
        for (n = 0; n < 100 && LOAD_DONE !== 1'b1; n++) tick();
    endtask

    task automatic test_reset_mid;
        WR_ACK = 1'b0;
        start_load();
        strobe(25'h00001, 8'h01);
        strobe(25'h08002, 8'h02);
        strobe(25'h10003, 8'h03);
        checks++;
        if (WR_REQ !== 1'b1 || BYTE_CNT !== 25'd3) begin
            errors++; $display("FAIL rstmid_queued: got req=%b cnt=%0d, expected 1 3", WR_REQ, BYTE_CNT);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if (WR_REQ !== 1'b0 || CORE_RST !== 1'b1 || BYTE_CNT !== 25'd0 || WR_SEL !== 4'd0) begin
            errors++; $display("FAIL rstmid_async: got req=%b rst=%b cnt=%0d sel=%b, expected 0 1 0 0000", WR_REQ, CORE_RST, BYTE_CNT, WR_SEL);
        end
        DL_ACTIVE = 1'b0;
        tick();
        RESET_N = 1'b1;
        WR_ACK = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (WR_REQ !== 1'b0 || CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0) begin
                errors++; $display("FAIL rstmid_idle: got req=%b rst=%b done=%b, expected 0 1 0", WR_REQ, CORE_RST, LOAD_DONE);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_hold();
        test_top();
        test_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
